// File: rtl/tl_pkg.sv
// Shared phase encodings and default timing constants for the traffic-light phase scheduler.
package tl_pkg;

  typedef enum logic [2:0] {
    PH_START = 3'b111,
    PH_NS_G  = 3'b011,
    PH_NS_Y  = 3'b010,
    PH_AR_NE = 3'b100,
    PH_EW_G  = 3'b000,
    PH_EW_Y  = 3'b001,
    PH_AR_EN = 3'b101
  } phase_e;

  localparam int unsigned DEF_T_WIDTH   = 8;
  localparam logic [7:0]  DEF_MIN_G     = 8'd5;
  localparam logic [7:0]  DEF_MAX_G     = 8'd20;
  localparam logic [7:0]  DEF_Y_TIME    = 8'd3;
  localparam logic [7:0]  DEF_AR_TIME   = 8'd2;
  localparam logic [7:0]  DEF_WALK_TIME = 8'd4;

  function automatic logic is_green(input phase_e ph);
    return (ph == PH_NS_G) || (ph == PH_EW_G);
  endfunction

endpackage

// File: rtl/tl_phase_sched_if.sv
// Bundle of the scheduler's sensor inputs and indication outputs for bench/system wiring.
interface tl_phase_sched_if;

  logic       ns_veh;
  logic       ew_veh;
  logic       ns_ped;
  logic       ew_ped;
  logic [2:0] state;
  logic       ns_walk;
  logic       ew_walk;
  logic       ns_ped_pend;
  logic       ew_ped_pend;

  // master drives the sensors and observes the lights; slave is the controller side
  modport master (
    output ns_veh, ew_veh, ns_ped, ew_ped,
    input  state, ns_walk, ew_walk, ns_ped_pend, ew_ped_pend
  );

  modport slave (
    input  ns_veh, ew_veh, ns_ped, ew_ped,
    output state, ns_walk, ew_walk, ns_ped_pend, ew_ped_pend
  );

endinterface

// File: rtl/tl_timer.sv
// Loadable up-counter with synchronous clear and a saturation ceiling; holds at or above i_sat.
module tl_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_sat,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q < i_sat) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/tl_phase_sched.sv
// Two-approach traffic-light phase scheduler with actuated greens and latched pedestrian calls.
module tl_phase_sched
  import tl_pkg::*;
#(
  parameter int unsigned T_WIDTH   = DEF_T_WIDTH,
  parameter logic [7:0]  MIN_G     = DEF_MIN_G,
  parameter logic [7:0]  MAX_G     = DEF_MAX_G,
  parameter logic [7:0]  Y_TIME    = DEF_Y_TIME,
  parameter logic [7:0]  AR_TIME   = DEF_AR_TIME,
  parameter logic [7:0]  WALK_TIME = DEF_WALK_TIME
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ns_veh,
  input  logic       i_ew_veh,
  input  logic       i_ns_ped,
  input  logic       i_ew_ped,
  output logic [2:0] o_state,
  output logic       o_ns_walk,
  output logic       o_ew_walk,
  output logic       o_ns_ped_pend,
  output logic       o_ew_ped_pend
);

  localparam logic [T_WIDTH-1:0] MIN_M1   = T_WIDTH'(MIN_G - 8'd1);
  localparam logic [T_WIDTH-1:0] MAX_M1   = T_WIDTH'(MAX_G - 8'd1);
  localparam logic [T_WIDTH-1:0] Y_M1     = T_WIDTH'(Y_TIME - 8'd1);
  localparam logic [T_WIDTH-1:0] AR_M1    = T_WIDTH'(AR_TIME - 8'd1);
  localparam logic [T_WIDTH-1:0] WALK_LIM = T_WIDTH'(WALK_TIME);

  phase_e             state_q, state_d;
  logic               ns_pend_q, ns_pend_d;
  logic               ew_pend_q, ew_pend_d;
  logic               ns_srv_q, ns_srv_d;
  logic               ew_srv_q, ew_srv_d;
  logic [T_WIDTH-1:0] g;
  logic [T_WIDTH-1:0] tmr_sat;
  logic               tmr_clr;
  logic               ns_leave, ew_leave;
  logic               ns_entry, ew_entry;

  // Green may end once min green is served and the other side is calling;
  // a waiting own vehicle can only hold it until max green.
  assign ns_leave = (g >= MIN_M1) && (i_ew_veh || ew_pend_q) && (!i_ns_veh || (g == MAX_M1));
  assign ew_leave = (g >= MIN_M1) && (i_ns_veh || ns_pend_q) && (!i_ew_veh || (g == MAX_M1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_START: if (g == AR_M1) state_d = PH_NS_G;
      PH_NS_G:  if (ns_leave)   state_d = PH_NS_Y;
      PH_NS_Y:  if (g == Y_M1)  state_d = PH_AR_NE;
      PH_AR_NE: if (g == AR_M1) state_d = PH_EW_G;
      PH_EW_G:  if (ew_leave)   state_d = PH_EW_Y;
      PH_EW_Y:  if (g == Y_M1)  state_d = PH_AR_EN;
      PH_AR_EN: if (g == AR_M1) state_d = PH_NS_G;
      default:                  state_d = PH_START;
    endcase
  end

  assign tmr_clr  = (state_d != state_q);
  assign tmr_sat  = is_green(state_q) ? MAX_M1 : '1;
  assign ns_entry = (state_d == PH_NS_G) && (state_q != PH_NS_G);
  assign ew_entry = (state_d == PH_EW_G) && (state_q != PH_EW_G);

  // A call pending at, or pulsed on, the entry edge is served by that green;
  // the served flag remembers it so walk is only shown for real requests.
  always_comb begin
    ns_pend_d = ns_entry ? 1'b0 : (ns_pend_q | i_ns_ped);
    ew_pend_d = ew_entry ? 1'b0 : (ew_pend_q | i_ew_ped);
    ns_srv_d  = ns_entry ? (ns_pend_q | i_ns_ped) : ns_srv_q;
    ew_srv_d  = ew_entry ? (ew_pend_q | i_ew_ped) : ew_srv_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= PH_START;
      ns_pend_q <= 1'b0;
      ew_pend_q <= 1'b0;
      ns_srv_q  <= 1'b0;
      ew_srv_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ns_pend_q <= ns_pend_d;
      ew_pend_q <= ew_pend_d;
      ns_srv_q  <= ns_srv_d;
      ew_srv_q  <= ew_srv_d;
    end
  end

  tl_timer #(
    .W (T_WIDTH)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (tmr_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_sat      (tmr_sat),
    .o_cnt      (g)
  );

  assign o_state       = state_q;
  assign o_ns_walk     = ns_srv_q && (state_q == PH_NS_G) && (g < WALK_LIM);
  assign o_ew_walk     = ew_srv_q && (state_q == PH_EW_G) && (g < WALK_LIM);
  assign o_ns_ped_pend = ns_pend_q;
  assign o_ew_ped_pend = ew_pend_q;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Directed bench for tl_phase_sched: phase sequencing, actuation, pedestrian calls and async reset.
module tb_tl_phase_sched;
  import tl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  tl_phase_sched_if bus ();

  tl_phase_sched dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ns_veh      (bus.ns_veh),
    .i_ew_veh      (bus.ew_veh),
    .i_ns_ped      (bus.ns_ped),
    .i_ew_ped      (bus.ew_ped),
    .o_state       (bus.state),
    .o_ns_walk     (bus.ns_walk),
    .o_ew_walk     (bus.ew_walk),
    .o_ns_ped_pend (bus.ns_ped_pend),
    .o_ew_ped_pend (bus.ew_ped_pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks phase and walks on n consecutive cycles, sampling at the falling edge.
  task automatic expect_run(input phase_e ph, input int n, input logic nsw, input logic eww,
                            input string tag);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d]/state", tag, i), 8'(bus.state), 8'(ph));
      chk($sformatf("%s[%0d]/ns_walk", tag, i), 8'(bus.ns_walk), 8'(nsw));
      chk($sformatf("%s[%0d]/ew_walk", tag, i), 8'(bus.ew_walk), 8'(eww));
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b1;
    bus.ns_veh  = 1'b0;
    bus.ew_veh  = 1'b0;
    bus.ns_ped  = 1'b0;
    bus.ew_ped  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst/state", 8'(bus.state), 8'(PH_START));
    chk("rst/ns_walk", 8'(bus.ns_walk), 8'd0);
    chk("rst/ew_walk", 8'(bus.ew_walk), 8'd0);
    chk("rst/ns_pend", 8'(bus.ns_ped_pend), 8'd0);
    chk("rst/ew_pend", 8'(bus.ew_ped_pend), 8'd0);

    // Release, START for two cycles, then NS green rests with no demand.
    @(negedge clk);
    rst_n = 1'b1;
    expect_run(PH_START, 2, 1'b0, 1'b0, "start");
    expect_run(PH_NS_G, 30, 1'b0, 1'b0, "rest_ns");

    // Demand from EW while NS green is saturated: leave on the next edge.
    bus.ew_veh = 1'b1;
    expect_run(PH_NS_G, 1, 1'b0, 1'b0, "b_nsg");
    expect_run(PH_NS_Y, 3, 1'b0, 1'b0, "b_nsy");
    expect_run(PH_AR_NE, 2, 1'b0, 1'b0, "b_arne");
    bus.ew_veh = 1'b0;
    expect_run(PH_EW_G, 1, 1'b0, 1'b0, "b_ewg0");
    bus.ns_veh = 1'b1;
    expect_run(PH_EW_G, 4, 1'b0, 1'b0, "b_ewg");
    expect_run(PH_EW_Y, 3, 1'b0, 1'b0, "b_ewy");
    expect_run(PH_AR_EN, 2, 1'b0, 1'b0, "b_aren");

    // EW vehicle raised at g=1 of an idle NS green ends it at min green.
    bus.ns_veh = 1'b0;
    expect_run(PH_NS_G, 1, 1'b0, 1'b0, "c_nsg0");
    bus.ew_veh = 1'b1;
    expect_run(PH_NS_G, 4, 1'b0, 1'b0, "c_nsg");
    expect_run(PH_NS_Y, 3, 1'b0, 1'b0, "c_nsy");
    expect_run(PH_AR_NE, 2, 1'b0, 1'b0, "c_arne");

    // Both approaches loaded: max green on each side, 50-cycle period.
    bus.ns_veh = 1'b1;
    bus.ew_veh = 1'b1;
    expect_run(PH_EW_G, 20, 1'b0, 1'b0, "d_ewg");
    expect_run(PH_EW_Y, 3, 1'b0, 1'b0, "d_ewy");
    expect_run(PH_AR_EN, 2, 1'b0, 1'b0, "d_aren");
    expect_run(PH_NS_G, 20, 1'b0, 1'b0, "d_nsg");
    expect_run(PH_NS_Y, 3, 1'b0, 1'b0, "d_nsy");
    expect_run(PH_AR_NE, 2, 1'b0, 1'b0, "d_arne");

    // EW pedestrian call during NS green.
    bus.ew_veh = 1'b0;
    expect_run(PH_EW_G, 5, 1'b0, 1'b0, "e_ewg");
    expect_run(PH_EW_Y, 3, 1'b0, 1'b0, "e_ewy");
    expect_run(PH_AR_EN, 2, 1'b0, 1'b0, "e_aren");
    bus.ns_veh = 1'b0;
    expect_run(PH_NS_G, 1, 1'b0, 1'b0, "e_nsg0");
    bus.ew_ped = 1'b1;
    chk("e_pend_before", 8'(bus.ew_ped_pend), 8'd0);
    expect_run(PH_NS_G, 1, 1'b0, 1'b0, "e_nsg1");
    bus.ew_ped = 1'b0;
    chk("e_pend_set", 8'(bus.ew_ped_pend), 8'd1);
    expect_run(PH_NS_G, 3, 1'b0, 1'b0, "e_nsg");
    chk("e_pend_in_y", 8'(bus.ew_ped_pend), 8'd1);
    expect_run(PH_NS_Y, 3, 1'b0, 1'b0, "e_nsy");
    expect_run(PH_AR_NE, 2, 1'b0, 1'b0, "e_arne");
    chk("e_pend_clr", 8'(bus.ew_ped_pend), 8'd0);
    expect_run(PH_EW_G, 4, 1'b0, 1'b1, "e_walk");
    expect_run(PH_EW_G, 3, 1'b0, 1'b0, "e_rest");

    // Pulse during own green after entry: latched for later, no extra walk.
    bus.ew_ped = 1'b1;
    expect_run(PH_EW_G, 1, 1'b0, 1'b0, "e2_pulse");
    bus.ew_ped = 1'b0;
    chk("e2_pend_latched", 8'(bus.ew_ped_pend), 8'd1);
    bus.ns_veh = 1'b1;
    expect_run(PH_EW_G, 1, 1'b0, 1'b0, "e2_ewg");
    expect_run(PH_EW_Y, 3, 1'b0, 1'b0, "e2_ewy");
    expect_run(PH_AR_EN, 2, 1'b0, 1'b0, "e2_aren");
    bus.ns_veh = 1'b0;
    chk("e2_pend_kept", 8'(bus.ew_ped_pend), 8'd1);
    expect_run(PH_NS_G, 5, 1'b0, 1'b0, "e2_nsg");
    expect_run(PH_NS_Y, 3, 1'b0, 1'b0, "e2_nsy");
    expect_run(PH_AR_NE, 2, 1'b0, 1'b0, "e2_arne");
    chk("e2_pend_clr", 8'(bus.ew_ped_pend), 8'd0);
    expect_run(PH_EW_G, 4, 1'b0, 1'b1, "e2_walk");

    // NS button pulsed on the exact AR_EN -> NS_G edge.
    bus.ns_veh = 1'b1;
    expect_run(PH_EW_G, 1, 1'b0, 1'b0, "f_ewg");
    expect_run(PH_EW_Y, 3, 1'b0, 1'b0, "f_ewy");
    expect_run(PH_AR_EN, 1, 1'b0, 1'b0, "f_aren0");
    bus.ns_ped = 1'b1;
    expect_run(PH_AR_EN, 1, 1'b0, 1'b0, "f_aren1");
    bus.ns_ped = 1'b0;
    chk("f_no_pend", 8'(bus.ns_ped_pend), 8'd0);
    expect_run(PH_NS_G, 4, 1'b1, 1'b0, "f_walk");
    expect_run(PH_NS_G, 2, 1'b0, 1'b0, "f_rest");
    chk("f_no_pend2", 8'(bus.ns_ped_pend), 8'd0);

    // Reset mid EW green with walk active.
    bus.ew_ped = 1'b1;
    bus.ns_veh = 1'b0;
    expect_run(PH_NS_G, 1, 1'b0, 1'b0, "g_nsg6");
    bus.ew_ped = 1'b0;
    expect_run(PH_NS_G, 1, 1'b0, 1'b0, "g_nsg7");
    expect_run(PH_NS_Y, 3, 1'b0, 1'b0, "g_nsy");
    expect_run(PH_AR_NE, 2, 1'b0, 1'b0, "g_arne");
    expect_run(PH_EW_G, 1, 1'b0, 1'b1, "g_walk0");
    bus.ns_ped = 1'b1;
    expect_run(PH_EW_G, 1, 1'b0, 1'b1, "g_walk1");
    bus.ns_ped = 1'b0;
    chk("g_walk2", 8'(bus.ew_walk), 8'd1);
    chk("g_ns_pend", 8'(bus.ns_ped_pend), 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("g_rst/state", 8'(bus.state), 8'(PH_START));
    chk("g_rst/ew_walk", 8'(bus.ew_walk), 8'd0);
    chk("g_rst/ns_walk", 8'(bus.ns_walk), 8'd0);
    chk("g_rst/ns_pend", 8'(bus.ns_ped_pend), 8'd0);
    chk("g_rst/ew_pend", 8'(bus.ew_ped_pend), 8'd0);
    repeat (3) @(negedge clk);
    chk("g_rst_hold/state", 8'(bus.state), 8'(PH_START));
    rst_n = 1'b1;
    expect_run(PH_START, 2, 1'b0, 1'b0, "g_start");
    expect_run(PH_NS_G, 3, 1'b0, 1'b0, "g_nsg");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
